// File: rtl/object_scheduler_if.sv
// Buffer-side and rasterizer-side handshake bundle for object_scheduler.
// master = scheduler; slave = buffer port b plus rasterizer front end.
interface object_scheduler_if;

    typedef struct packed {
        logic [15:0] x0;
        logic [15:0] y0;
        logic [15:0] x1;
        logic [15:0] y1;
        logic [15:0] x2;
        logic [15:0] y2;
        logic [23:0] color;
    } object_t;

    object_t buf_data;
    logic    buf_read_end;
    logic    buf_empty;
    logic    buf_read;
    logic    buf_switch;
    logic    obj_valid;
    object_t obj;
    logic    obj_ready;
    logic    raster_idle;

    modport master (
        input  buf_data, buf_read_end, buf_empty, obj_ready, raster_idle,
        output buf_read, buf_switch, obj_valid, obj
    );

    modport slave (
        output buf_data, buf_read_end, buf_empty, obj_ready, raster_idle,
        input  buf_read, buf_switch, obj_valid, obj
    );

endinterface

// File: rtl/object_scheduler.sv
// Per-frame sequencer: rewinds the object buffer, then issues each object to the rasterizer.
// Optional ready-wait watchdog enabled by defining SCHED_TIMEOUT_EN.
module object_scheduler #(
    parameter int unsigned MAX_OBJECTS    = 50,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               frame_start,
    object_scheduler_if.master                 bus,
    output logic                               frame_done,
    output logic                               busy,
    output logic [$clog2(MAX_OBJECTS + 1)-1:0] obj_count,
    output logic                               overrun,
    output logic                               timeout
);

    localparam int unsigned CountWidth = $clog2(MAX_OBJECTS + 1);
    localparam logic [CountWidth-1:0] CountLast = CountWidth'(MAX_OBJECTS - 1);
    localparam logic [CountWidth-1:0] CountMax  = CountWidth'(MAX_OBJECTS);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StSwitch  = 3'd1;
    localparam logic [2:0] StFetch   = 3'd2;
    localparam logic [2:0] StIssue   = 3'd3;
    localparam logic [2:0] StAdvance = 3'd4;
    localparam logic [2:0] StGap     = 3'd5;
    localparam logic [2:0] StDrain   = 3'd6;

    if (MAX_OBJECTS < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("object_scheduler: MAX_OBJECTS and TIMEOUT_CYCLES must be nonzero");
    end

    logic [2:0] state_q, state_d;
    logic       last_q;
    logic       handshake;
    logic       drop;
    logic       start;

    assign busy           = (state_q != StIdle);
    assign bus.buf_switch = (state_q == StSwitch);
    assign bus.obj_valid  = (state_q == StIssue);
    assign bus.buf_read   = (state_q == StAdvance);

    assign handshake = (state_q == StIssue) && bus.obj_ready;
    // A start request coinciding with frame_done is treated as an overrun, not a new frame.
    assign start     = (state_q == StIdle) && frame_start && !frame_done;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (start) state_d = StSwitch;
            StSwitch:  state_d = bus.buf_empty ? StDrain : StFetch;
            StFetch:   state_d = StIssue;
            StIssue:   if (handshake || drop) state_d = last_q ? StDrain : StAdvance;
            StAdvance: state_d = StGap;
            StGap:     state_d = StFetch;
            StDrain:   if (bus.raster_idle) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            bus.obj    <= '0;
            last_q     <= 1'b0;
            obj_count  <= '0;
            overrun    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_done <= (state_q == StDrain) && bus.raster_idle;
            if (frame_start && (busy || frame_done)) overrun <= 1'b1;
            if (start) begin
                obj_count <= '0;
            end else if (handshake && obj_count != CountMax) begin
                obj_count <= obj_count + 1'b1;
            end
            if (state_q == StFetch) begin
                bus.obj <= bus.buf_data;
                // The cap forces termination even if the buffer never flags its last entry.
                last_q  <= bus.buf_read_end || (obj_count == CountLast);
            end
        end
    end

`ifdef SCHED_TIMEOUT_EN
    localparam int unsigned WaitWidth = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WaitWidth-1:0] WaitLast = WaitWidth'(TIMEOUT_CYCLES - 1);

    logic [WaitWidth-1:0] wait_q;

    assign drop = (state_q == StIssue) && !bus.obj_ready && (wait_q == WaitLast);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_q  <= '0;
            timeout <= 1'b0;
        end else begin
            if (state_q == StFetch) begin
                wait_q <= '0;
            end else if ((state_q == StIssue) && !bus.obj_ready) begin
                wait_q <= wait_q + 1'b1;
            end
            if (drop) timeout <= 1'b1;
        end
    end
`else
    assign drop    = 1'b0;
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_object_scheduler.sv
// Directed self-checking bench for object_scheduler with a behavioural object buffer model.
module tb_object_scheduler;

    typedef struct packed {
        logic [15:0] x0;
        logic [15:0] y0;
        logic [15:0] x1;
        logic [15:0] y1;
        logic [15:0] x2;
        logic [15:0] y2;
        logic [23:0] color;
    } obj_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       frame_start = 1'b0;
    logic       frame_done, busy, overrun, timeout;
    logic [5:0] obj_count;

    object_scheduler_if bus ();

    object_scheduler #(
        .MAX_OBJECTS   (50),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .frame_start(frame_start),
        .bus        (bus),
        .frame_done (frame_done),
        .busy       (busy),
        .obj_count  (obj_count),
        .overrun    (overrun),
        .timeout    (timeout)
    );

    always #5 clock = ~clock;

    // Buffer model: edge-triggered read advance, rewind on switch.
    obj_t       mem [64];
    int         n_objs = 7;
    logic       end_dis = 1'b0;
    logic [5:0] rd_ptr = '0;
    logic       rd_prev = 1'b0;

    assign bus.buf_data     = mem[rd_ptr];
    assign bus.buf_empty    = (n_objs == 0);
    assign bus.buf_read_end = !end_dis && (n_objs > 0) && (int'(rd_ptr) == n_objs - 1);

    always @(posedge clock) begin
        rd_prev <= bus.buf_read;
        if (bus.buf_switch) rd_ptr <= '0;
        else if (bus.buf_read && !rd_prev && rd_ptr != 6'd63) rd_ptr <= rd_ptr + 1'b1;
    end

    // Rasterizer model: 0 = constant, 1 = ready one cycle in three, 2 = refuses mem[1].
    int         ready_mode = 0;
    logic       ready_val = 1'b1;
    logic       idle_val = 1'b1;
    logic [1:0] phase = '0;

    always @(posedge clock) phase <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;

    assign bus.obj_ready   = (ready_mode == 1) ? (phase == 2'd0) :
                             (ready_mode == 2) ? (bus.obj !== mem[1]) : ready_val;
    assign bus.raster_idle = idle_val;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Monitor, sampled mid-cycle.
    obj_t acc[$];
    int   n_valid, n_reads, n_switch, n_done, n_stall, viol;
    int   switch_cyc, done_cyc, first_valid_cyc;
    logic prev_read = 1'b0, prev_stall = 1'b0;
    obj_t prev_obj;

    always @(negedge clock) begin
        if (bus.obj_valid && bus.obj_ready) acc.push_back(bus.obj);
        if (bus.obj_valid) begin
            n_valid <= n_valid + 1;
            if (first_valid_cyc < 0) first_valid_cyc <= cyc;
        end
        if (bus.obj_valid && !bus.obj_ready) n_stall <= n_stall + 1;
        if (bus.buf_read) n_reads <= n_reads + 1;
        if (bus.buf_switch) begin
            n_switch   <= n_switch + 1;
            switch_cyc <= cyc;
        end
        if (frame_done) begin
            n_done   <= n_done + 1;
            done_cyc <= cyc;
        end
        if ((bus.buf_read && prev_read) || (bus.buf_read && bus.buf_switch) ||
            (prev_stall && bus.obj_valid && bus.obj !== prev_obj)) viol <= viol + 1;
        prev_read  <= bus.buf_read;
        prev_stall <= bus.obj_valid && !bus.obj_ready;
        prev_obj   <= bus.obj;
    end

    int n_checks = 0;
    int n_pass = 0;
    int fs_cyc;

    task automatic clear_mon();
        acc.delete();
        n_valid = 0; n_reads = 0; n_switch = 0; n_done = 0; n_stall = 0; viol = 0;
        switch_cyc = -1; done_cyc = -1; first_valid_cyc = -1;
    endtask

    task automatic start_frame();
        @(posedge clock); #1 frame_start = 1'b1;
        fs_cyc = cyc;
        @(posedge clock); #1 frame_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int start_n;
        start_n = n_done;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clock); #1;
            if (n_done != start_n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_reset();
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
    endtask

    function automatic int order_errs(input int n);
        int e = 0;
        for (int i = 0; i < n && i < acc.size(); i++) if (acc[i] !== mem[i]) e++;
        return e;
    endfunction

    task automatic test_reset();
        repeat (2) @(posedge clock);
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else n_pass++;
        n_checks++; if (frame_done !== 1'b0) $display("FAIL reset_done: got %0b want 0", frame_done); else n_pass++;
        n_checks++; if (obj_count !== 6'd0) $display("FAIL reset_count: got %0d want 0", obj_count); else n_pass++;
        n_checks++; if (overrun !== 1'b0 || timeout !== 1'b0) $display("FAIL reset_sticky: got %0b%0b want 00", overrun, timeout); else n_pass++;
        n_checks++; if ({bus.obj_valid, bus.buf_read, bus.buf_switch} !== 3'b000) $display("FAIL reset_strobes: got %0b want 000", {bus.obj_valid, bus.buf_read, bus.buf_switch}); else n_pass++;
        n_checks++; if (bus.obj !== '0) $display("FAIL reset_obj: got %0h want 0", bus.obj); else n_pass++;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL idle_busy: got %0b want 0", busy); else n_pass++;
    endtask

    task automatic test_basic();
        bit ok;
        n_objs = 7; ready_mode = 0; ready_val = 1'b1;
        clear_mon();
        start_frame();
        wait_done(200, ok);
        n_checks++; if (!ok) $display("FAIL basic_done_timeout: got none want frame_done"); else n_pass++;
        n_checks++; if (switch_cyc !== fs_cyc + 1) $display("FAIL basic_switch_lat: got %0d want %0d", switch_cyc, fs_cyc + 1); else n_pass++;
        n_checks++; if (first_valid_cyc !== fs_cyc + 3) $display("FAIL basic_valid_lat: got %0d want %0d", first_valid_cyc, fs_cyc + 3); else n_pass++;
        n_checks++; if (acc.size() !== 7) $display("FAIL basic_n_obj: got %0d want 7", acc.size()); else n_pass++;
        n_checks++; if (order_errs(7) !== 0) $display("FAIL basic_order: got %0d errors want 0", order_errs(7)); else n_pass++;
        n_checks++; if (acc.size() < 7 || acc[6].color !== 24'hFC8210) $display("FAIL basic_last_color: got %0d objs want color fc8210", acc.size()); else n_pass++;
        n_checks++; if (n_reads !== 6) $display("FAIL basic_reads: got %0d want 6", n_reads); else n_pass++;
        n_checks++; if (n_switch !== 1) $display("FAIL basic_switches: got %0d want 1", n_switch); else n_pass++;
        n_checks++; if (obj_count !== 6'd7) $display("FAIL basic_count: got %0d want 7", obj_count); else n_pass++;
        n_checks++; if (done_cyc !== fs_cyc + 29) $display("FAIL basic_done_cyc: got %0d want %0d", done_cyc, fs_cyc + 29); else n_pass++;
        n_checks++; if (viol !== 0) $display("FAIL basic_protocol: got %0d violations want 0", viol); else n_pass++;
        @(posedge clock); #1;
        n_checks++; if (frame_done !== 1'b0 || busy !== 1'b0) $display("FAIL basic_after: got done=%0b busy=%0b want 0 0", frame_done, busy); else n_pass++;
    endtask

    task automatic test_ready_toggle();
        bit ok;
        n_objs = 7; ready_mode = 1;
        clear_mon();
        start_frame();
        wait_done(500, ok);
        ready_mode = 0;
        n_checks++; if (!ok) $display("FAIL toggle_done_timeout: got none want frame_done"); else n_pass++;
        n_checks++; if (acc.size() !== 7) $display("FAIL toggle_n_obj: got %0d want 7", acc.size()); else n_pass++;
        n_checks++; if (order_errs(7) !== 0) $display("FAIL toggle_order: got %0d errors want 0", order_errs(7)); else n_pass++;
        n_checks++; if (viol !== 0) $display("FAIL toggle_stable: got %0d violations want 0", viol); else n_pass++;
        n_checks++; if (n_stall == 0) $display("FAIL toggle_stalls: got 0 stall cycles want >0"); else n_pass++;
        n_checks++; if (obj_count !== 6'd7) $display("FAIL toggle_count: got %0d want 7", obj_count); else n_pass++;
`ifndef SCHED_TIMEOUT_EN
        n_checks++; if (timeout !== 1'b0) $display("FAIL toggle_timeout: got %0b want 0", timeout); else n_pass++;
`endif
    endtask

    task automatic test_empty();
        bit ok;
        n_objs = 0;
        clear_mon();
        start_frame();
        wait_done(50, ok);
        n_checks++; if (!ok) $display("FAIL empty_done_timeout: got none want frame_done"); else n_pass++;
        n_checks++; if (n_valid !== 0) $display("FAIL empty_valid: got %0d want 0", n_valid); else n_pass++;
        n_checks++; if (done_cyc - switch_cyc !== 2) $display("FAIL empty_done_lat: got %0d want 2", done_cyc - switch_cyc); else n_pass++;
        n_checks++; if (obj_count !== 6'd0) $display("FAIL empty_count: got %0d want 0", obj_count); else n_pass++;
        n_checks++; if (n_reads !== 0) $display("FAIL empty_reads: got %0d want 0", n_reads); else n_pass++;
    endtask

    task automatic test_drain_wait();
        bit ok;
        int rel_cyc;
        n_objs = 0; idle_val = 1'b0;
        clear_mon();
        start_frame();
        repeat (6) @(posedge clock);
        #1;
        n_checks++; if (n_done !== 0 || busy !== 1'b1) $display("FAIL drain_hold: got done=%0d busy=%0b want 0 1", n_done, busy); else n_pass++;
        idle_val = 1'b1;
        rel_cyc = cyc;
        wait_done(20, ok);
        n_checks++; if (!ok || done_cyc !== rel_cyc + 1) $display("FAIL drain_release: got %0d want %0d", done_cyc, rel_cyc + 1); else n_pass++;
    endtask

    task automatic test_overrun();
        bit ok;
        n_objs = 7;
        clear_mon();
        start_frame();
        while (cyc < fs_cyc + 11) begin
            @(posedge clock); #1;
        end
        frame_start = 1'b1;
        n_checks++; if (bus.obj_valid !== 1'b1 || acc.size() !== 2) $display("FAIL ovr_in_obj3: got valid=%0b n=%0d want 1 2", bus.obj_valid, acc.size()); else n_pass++;
        @(posedge clock); #1 frame_start = 1'b0;
        n_checks++; if (overrun !== 1'b1) $display("FAIL ovr_flag: got %0b want 1", overrun); else n_pass++;
        wait_done(200, ok);
        n_checks++; if (!ok || obj_count !== 6'd7) $display("FAIL ovr_count: got %0d want 7", obj_count); else n_pass++;
        n_checks++; if (n_switch !== 1 || order_errs(7) !== 0 || acc.size() !== 7) $display("FAIL ovr_frame: got sw=%0d n=%0d want 1 7", n_switch, acc.size()); else n_pass++;
        clear_mon();
        start_frame();
        wait_done(200, ok);
        n_checks++; if (!ok || n_switch !== 1 || acc.size() !== 7) $display("FAIL ovr_next_frame: got sw=%0d n=%0d want 1 7", n_switch, acc.size()); else n_pass++;
        n_checks++; if (overrun !== 1'b1) $display("FAIL ovr_sticky: got %0b want 1", overrun); else n_pass++;
    endtask

    task automatic test_done_collision();
        pulse_reset();
        n_objs = 0;
        clear_mon();
        start_frame();
        @(posedge clock); #1;
        @(posedge clock); #1 frame_start = 1'b1;
        n_checks++; if (frame_done !== 1'b1) $display("FAIL coll_done: got %0b want 1", frame_done); else n_pass++;
        @(posedge clock); #1 frame_start = 1'b0;
        n_checks++; if (overrun !== 1'b1) $display("FAIL coll_overrun: got %0b want 1", overrun); else n_pass++;
        repeat (3) @(posedge clock);
        #1;
        n_checks++; if (busy !== 1'b0 || n_switch !== 1 || n_done !== 1) $display("FAIL coll_no_start: got busy=%0b sw=%0d done=%0d want 0 1 1", busy, n_switch, n_done); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit found;
        n_objs = 7;
        clear_mon();
        start_frame();
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clock); #1;
            if (bus.buf_read) begin
                found = 1'b1;
                break;
            end
        end
        n_checks++; if (!found) $display("FAIL mid_advance: got none want buf_read"); else n_pass++;
        reset = 1'b1;
        #1;
        n_checks++; if ({busy, bus.buf_read, bus.obj_valid, overrun, frame_done} !== 5'b0) $display("FAIL mid_outputs: got %0b want 0", {busy, bus.buf_read, bus.obj_valid, overrun, frame_done}); else n_pass++;
        n_checks++; if (obj_count !== 6'd0 || bus.obj !== '0) $display("FAIL mid_regs: got count=%0d obj=%0h want 0 0", obj_count, bus.obj); else n_pass++;
        @(posedge clock); #1 reset = 1'b0;
        clear_mon();
        start_frame();
        wait_done(200, ok);
        n_checks++; if (!ok || acc.size() !== 7 || order_errs(7) !== 0) $display("FAIL mid_reissue: got n=%0d errs=%0d want 7 0", acc.size(), order_errs(7)); else n_pass++;
    endtask

    task automatic test_cap();
        bit ok;
        n_objs = 64; end_dis = 1'b1;
        clear_mon();
        start_frame();
        wait_done(400, ok);
        end_dis = 1'b0;
        n_checks++; if (!ok) $display("FAIL cap_done_timeout: got none want frame_done"); else n_pass++;
        n_checks++; if (obj_count !== 6'd50 || acc.size() !== 50) $display("FAIL cap_count: got %0d/%0d want 50", obj_count, acc.size()); else n_pass++;
        n_checks++; if (n_reads !== 49 || order_errs(50) !== 0) $display("FAIL cap_walk: got reads=%0d errs=%0d want 49 0", n_reads, order_errs(50)); else n_pass++;
    endtask

`ifdef SCHED_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        pulse_reset();
        n_objs = 7; ready_mode = 2;
        clear_mon();
        start_frame();
        wait_done(300, ok);
        ready_mode = 0;
        n_checks++; if (!ok) $display("FAIL to_done_timeout: got none want frame_done"); else n_pass++;
        n_checks++; if (timeout !== 1'b1) $display("FAIL to_flag: got %0b want 1", timeout); else n_pass++;
        n_checks++; if (obj_count !== 6'd6) $display("FAIL to_count: got %0d want 6", obj_count); else n_pass++;
        n_checks++; if (acc.size() !== 6 || acc[1] !== mem[2]) $display("FAIL to_skip: got n=%0d want 6 with mem[2] second", acc.size()); else n_pass++;
    endtask
`endif

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i].x0 = 16'(i);
            mem[i].y0 = 16'(i + 100);
            mem[i].x1 = 16'(i * 3);
            mem[i].y1 = 16'(i + 200);
            mem[i].x2 = 16'(i * 5);
            mem[i].y2 = 16'(i + 300);
            mem[i].color = 24'h000110 + 24'(i * 24'h010203);
        end
        mem[6].color = 24'hFC8210;
        clear_mon();
        test_reset();
        test_basic();
        test_ready_toggle();
        test_empty();
        test_drain_wait();
        test_overrun();
        test_done_collision();
        test_reset_mid();
        test_cap();
`ifdef SCHED_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/object_scheduler.md
Name: object_scheduler

Overview:
- Per-frame sequencer for the object buffer.
- On each frame start it rewinds the buffer's read port, then walks every stored object in order.
- Each object is presented to the triangle rasterizer over a valid/ready handshake, and a frame is closed once the rasterizer drains.
- Sits between display timing, object_buffer port b and the rasterizer front end.

Parameters:
- MAX_OBJECTS, 50: buffer capacity; hard cap on objects issued per frame.
- TIMEOUT_CYCLES, 1024: ready-wait limit, used only when SCHED_TIMEOUT_EN is defined.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- frame_start  input  1  one-cycle pulse from display timing (vblank start)
- buf_data  input  object_t  object at the buffer read cursor (combinational from buffer)
- buf_read_end  input  1  buffer flag: read cursor is at the last written object
- buf_empty  input  1  buffer holds zero objects
- buf_read  output  1  read-advance pulse to buffer (buffer advances on rising edge of this level)
- buf_switch  output  1  one-cycle pulse; rewinds buffer read cursor to 0
- obj_valid  output  1  obj holds a valid object
- obj  output  object_t  registered object to rasterizer
- obj_ready  input  1  rasterizer accepts obj this cycle
- raster_idle  input  1  rasterizer has finished all accepted objects
- frame_done  output  1  one-cycle pulse when the frame is fully rasterized
- busy  output  1  high in every state except IDLE
- obj_count  output  $clog2(MAX_OBJECTS+1)  objects issued this frame; holds its value after frame_done
- overrun  output  1  sticky: frame_start arrived while busy
- timeout  output  1  sticky: an object was dropped by the watchdog

Behaviour:
- Reset (async): state IDLE; all outputs 0; obj cleared to '0; obj_count 0; overrun and timeout cleared.
- All outputs are registered or decoded from the registered state; no combinational input-to-output path.
- FSM states: IDLE, SWITCH, FETCH, ISSUE, ADVANCE, GAP, DRAIN.
- IDLE: frame_start=1 -> SWITCH; obj_count <= 0.
- SWITCH: buf_switch=1 for exactly this cycle.
  - buf_empty=1 -> DRAIN.
  - Otherwise -> FETCH.
- FETCH: obj <= buf_data; last <= buf_read_end | (obj_count == MAX_OBJECTS-1); -> ISSUE.
- ISSUE: obj_valid=1; obj held stable until the handshake.
  - Handshake is obj_valid & obj_ready at a clock edge: obj_count += 1.
  - last=1 -> DRAIN; otherwise -> ADVANCE.
- ADVANCE: buf_read=1 for one cycle; -> GAP.
- GAP: buf_read=0 for one cycle, so the buffer's edge detector re-arms and its cursor has settled; -> FETCH.
- DRAIN: wait for raster_idle=1, then frame_done=1 for one cycle; -> IDLE.
- Latency: frame_start sampled at edge N -> buf_switch high in cycle N+1 -> obj_valid high in cycle N+3.
- Throughput with obj_ready held high: 4 cycles per object (ISSUE, ADVANCE, GAP, FETCH).
- buf_read is never high in two consecutive cycles.
- buf_read and buf_switch are never high in the same cycle.
- frame_start while busy: ignored; overrun <= 1 (sticky until reset). The frame in progress continues.
- frame_start in the same cycle as frame_done: frame_done still pulses; the FSM enters IDLE; the pulse is counted as overrun and not started.
- obj_count saturates at MAX_OBJECTS.
  - The cap forces last, so a buffer whose read_end never asserts still terminates.
- Reset mid-frame: immediate IDLE. An object already accepted by the rasterizer is not recalled.

Optional Feature:
- Macro: SCHED_TIMEOUT_EN.
- Defined:
  - A counter runs while in ISSUE with obj_ready=0, and clears on every entry to ISSUE.
  - When it reaches TIMEOUT_CYCLES, the object is dropped: obj_valid falls, obj_count is not incremented, and timeout <= 1 (sticky).
  - The FSM then follows the handshake path: last -> DRAIN, else -> ADVANCE.
- Undefined: no counter; ISSUE waits indefinitely; timeout tied to 0.

Test Plan:
- Buffer preloaded with 7 objects, obj_ready=1, raster_idle=1, frame_start pulse -> buf_switch pulse 1 cycle later; 7 handshakes in buffer order (mem[0]..mem[6], mem[6] color 'hFC8210); buf_read pulses 6 times; obj_count=7; frame_done 1 cycle after the 7th handshake plus the DRAIN cycle.
- obj_ready toggled 1-of-3 cycles, same 7 objects -> obj stable while obj_valid && !obj_ready; no object duplicated or skipped; obj_count=7.
- buf_empty=1, frame_start -> no obj_valid; frame_done 2 cycles after buf_switch; obj_count=0.
- Second frame_start during ISSUE of object 3 -> overrun=1; frame finishes with obj_count=7; a later frame_start begins a new frame normally.
- Reset asserted during ADVANCE -> all outputs 0 immediately; next frame_start reissues from mem[0].
- SCHED_TIMEOUT_EN with TIMEOUT_CYCLES=8, obj_ready stuck 0 on object 2 -> timeout=1; obj_count=6; frame_done still asserted.
